// File: rtl/md_pkg.sv
// Shared constants for the mult/div issue logic: SPECIAL opcode, funct codes
// and the issue FSM state type.
package md_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BUSY  = 2'd2,
        DRAIN = 2'd3
    } md_state_t;

endpackage

// File: rtl/md_issue_if.sv
// Handshake between the issue logic (master) and the mult/div unit (slave).
interface md_issue_if;

    logic md_start;
    logic md_md;
    logic md_sign;
    logic md_hlwrite;
    logic md_busy;

    modport master (
        output md_start,
        output md_md,
        output md_sign,
        output md_hlwrite,
        input  md_busy
    );

    modport slave (
        input  md_start,
        input  md_md,
        input  md_sign,
        input  md_hlwrite,
        output md_busy
    );

endinterface

// File: rtl/md_decode.sv
// Combinational decode of the E-stage instruction into mult/div unit classes.
module md_decode
    import md_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       valid,
    output logic       is_mdop,
    output logic       is_mf,
    output logic       is_mt,
    output logic       md,
    output logic       sign
);

    logic special;

    assign special = valid && (op == OP_SPECIAL);

    always_comb begin
        is_mdop = 1'b0;
        is_mf   = 1'b0;
        is_mt   = 1'b0;
        if (special) begin
            unique case (funct)
                F_MULT, F_MULTU, F_DIV, F_DIVU: is_mdop = 1'b1;
                F_MFHI, F_MFLO:                 is_mf   = 1'b1;
                F_MTHI, F_MTLO:                 is_mt   = 1'b1;
                default: ;
            endcase
        end
    end

    // funct[1] separates div from mult and LO from HI; funct[0] marks the unsigned forms.
    assign md   = funct[1];
    assign sign = ~funct[0];

endmodule

// File: rtl/md_issue.sv
// Mult/div issue control: starts the unit, writes HI/LO, stalls F/D while busy.
// Optional feature macro: MD_DIV0_TRAP_EN (divide-by-zero trap pulse on div0_exc).
module md_issue
    import md_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op_e,
    input  logic [5:0]        funct_e,
    input  logic              valid_e,
    input  logic              md_use_d,
    input  logic [DATA_W-1:0] rt_val_e,
    input  logic              interrupt_req,
    md_issue_if.master        mdu,
    output logic              hl_sel,
    output logic              stall_d,
    output logic              div0_exc
);

    md_state_t state, state_nxt;

    logic is_mdop, is_mf, is_mt, dec_md, dec_sign;
    logic div_zero, issue_ok, start, hlwrite;

    md_decode u_decode (
        .op      (op_e),
        .funct   (funct_e),
        .valid   (valid_e),
        .is_mdop (is_mdop),
        .is_mf   (is_mf),
        .is_mt   (is_mt),
        .md      (dec_md),
        .sign    (dec_sign)
    );

    // Reset gates every output in the same cycle, not only the registered state.
    assign issue_ok = (state == IDLE) && !interrupt_req && !reset;
    assign div_zero = is_mdop && dec_md && (rt_val_e == '0);
    assign start    = is_mdop && issue_ok && !div_zero;
    assign hlwrite  = is_mt && issue_ok;

    assign mdu.md_start   = start;
    assign mdu.md_hlwrite = hlwrite;
    assign mdu.md_md      = (start || hlwrite) ? dec_md : 1'b0;
    assign mdu.md_sign    = start ? dec_sign : 1'b0;

    assign hl_sel  = is_mf && !reset && funct_e[1];
    assign stall_d = md_use_d && !reset && ((state != IDLE) || start);

`ifdef MD_DIV0_TRAP_EN
    assign div0_exc = div_zero && issue_ok;
`else
    assign div0_exc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ARMED absorbs the cycle where the unit's registered Busy has not risen yet;
    // DRAIN covers the HI/LO write one cycle after Busy falls.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = ARMED;
            ARMED:   state_nxt = BUSY;
            BUSY:    if (!mdu.md_busy) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_issue.sv
// Directed bench for md_issue: issue, stall window, div-by-zero, interrupt and reset cases.
module tb_md_issue;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op_e, funct_e;
    logic        valid_e, md_use_d, interrupt_req;
    logic [31:0] rt_val_e;
    logic        hl_sel, stall_d, div0_exc;

    int checks = 0;
    int errors = 0;

`ifdef MD_DIV0_TRAP_EN
    localparam logic DIV0_EXP = 1'b1;
`else
    localparam logic DIV0_EXP = 1'b0;
`endif

    md_issue_if mdu ();

    md_issue #(.DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .op_e          (op_e),
        .funct_e       (funct_e),
        .valid_e       (valid_e),
        .md_use_d      (md_use_d),
        .rt_val_e      (rt_val_e),
        .interrupt_req (interrupt_req),
        .mdu           (mdu),
        .hl_sel        (hl_sel),
        .stall_d       (stall_d),
        .div0_exc      (div0_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic v);
        op_e    = op;
        funct_e = fn;
        valid_e = v;
        #1;
    endtask

    initial begin
        reset = 1'b1; op_e = '0; funct_e = '0; valid_e = 1'b0; md_use_d = 1'b0;
        rt_val_e = 32'd0; interrupt_req = 1'b0; mdu.md_busy = 1'b0;

        // Reset held: state IDLE and a mult in E must not start the unit.
        tick(); tick();
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        instr(OP_SPECIAL, F_MULT, 1'b1);
        chk("rst_start", 32'(mdu.md_start), 0);
        md_use_d = 1'b1; #1;
        chk("rst_stall", 32'(stall_d), 0);
        md_use_d = 1'b0;
        tick(); reset = 1'b0; instr(OP_SPECIAL, 6'h00, 1'b0);

        // mult issue
        instr(OP_SPECIAL, F_MULT, 1'b1);
        chk("mult_start", 32'(mdu.md_start), 1);
        chk("mult_md", 32'(mdu.md_md), 0);
        chk("mult_sign", 32'(mdu.md_sign), 1);
        chk("mult_stall_nouse", 32'(stall_d), 0);
        tick();
        chk("mult_armed", 32'(dut.state), 32'(ARMED));
        instr(OP_SPECIAL, F_MULTU, 1'b1);
        chk("armed_nostart", 32'(mdu.md_start), 0);
        tick(); mdu.md_busy = 1'b1;
        chk("mult_busy", 32'(dut.state), 32'(BUSY));
        instr(OP_SPECIAL, F_MTHI, 1'b1);
        chk("busy_nohlw", 32'(mdu.md_hlwrite), 0);
        instr(OP_SPECIAL, 6'h00, 1'b0);
        tick();
        chk("busy_hold", 32'(dut.state), 32'(BUSY));
        mdu.md_busy = 1'b0;
        tick();
        chk("mult_drain", 32'(dut.state), 32'(DRAIN));
        tick();
        chk("mult_idle", 32'(dut.state), 32'(IDLE));

        // divu with mflo waiting in D: stall from issue through DRAIN
        rt_val_e = 32'd5; md_use_d = 1'b1;
        instr(OP_SPECIAL, F_DIVU, 1'b1);
        chk("divu_start", 32'(mdu.md_start), 1);
        chk("divu_md", 32'(mdu.md_md), 1);
        chk("divu_sign", 32'(mdu.md_sign), 0);
        chk("divu_stall_issue", 32'(stall_d), 1);
        tick(); instr(OP_SPECIAL, 6'h00, 1'b0);
        chk("divu_armed", 32'(dut.state), 32'(ARMED));
        chk("divu_stall_armed", 32'(stall_d), 1);
        tick(); mdu.md_busy = 1'b1; #1;
        for (int i = 0; i < 9; i++) begin
            chk("divu_busy_state", 32'(dut.state), 32'(BUSY));
            chk("divu_stall_busy", 32'(stall_d), 1);
            tick();
        end
        mdu.md_busy = 1'b0; #1;
        chk("divu_busy_fall", 32'(dut.state), 32'(BUSY));
        tick();
        chk("divu_drain", 32'(dut.state), 32'(DRAIN));
        chk("divu_stall_drain", 32'(stall_d), 1);
        tick();
        chk("divu_idle", 32'(dut.state), 32'(IDLE));
        chk("divu_stall_clear", 32'(stall_d), 0);
        md_use_d = 1'b0;

        // mflo / mfhi select; non-SPECIAL opcode is a no-op
        instr(OP_SPECIAL, F_MFLO, 1'b1);
        chk("mflo_sel", 32'(hl_sel), 1);
        chk("mflo_nostart", 32'(mdu.md_start), 0);
        instr(OP_SPECIAL, F_MFHI, 1'b1);
        chk("mfhi_sel", 32'(hl_sel), 0);
        instr(6'h01, F_MFLO, 1'b1);
        chk("nonspecial_sel", 32'(hl_sel), 0);
        instr(6'h01, F_MULT, 1'b1);
        chk("nonspecial_start", 32'(mdu.md_start), 0);
        instr(OP_SPECIAL, F_MULT, 1'b0);
        chk("invalid_start", 32'(mdu.md_start), 0);

        // mtlo writes LO
        instr(OP_SPECIAL, F_MTLO, 1'b1);
        chk("mtlo_hlw", 32'(mdu.md_hlwrite), 1);
        chk("mtlo_md", 32'(mdu.md_md), 1);
        tick(); instr(OP_SPECIAL, 6'h00, 1'b0);
        chk("mtlo_idle", 32'(dut.state), 32'(IDLE));

        // div by zero: no issue, optional one-cycle trap pulse
        rt_val_e = 32'd0;
        instr(OP_SPECIAL, F_DIV, 1'b1);
        chk("div0_start", 32'(mdu.md_start), 0);
        chk("div0_exc", 32'(div0_exc), 32'(DIV0_EXP));
        tick(); instr(OP_SPECIAL, 6'h00, 1'b0);
        chk("div0_state", 32'(dut.state), 32'(IDLE));
        chk("div0_exc_gone", 32'(div0_exc), 0);
        interrupt_req = 1'b1;
        instr(OP_SPECIAL, F_DIVU, 1'b1);
        chk("div0_irq_exc", 32'(div0_exc), 0);
        instr(OP_SPECIAL, 6'h00, 1'b0);

        // interrupt suppresses issue in IDLE
        rt_val_e = 32'd7;
        instr(OP_SPECIAL, F_MULT, 1'b1);
        chk("irq_start", 32'(mdu.md_start), 0);
        instr(OP_SPECIAL, F_MTHI, 1'b1);
        chk("irq_hlw", 32'(mdu.md_hlwrite), 0);
        instr(OP_SPECIAL, F_MULT, 1'b1);
        tick();
        chk("irq_idle", 32'(dut.state), 32'(IDLE));

        // interrupt during BUSY does not disturb the running op
        interrupt_req = 1'b0; #1;
        chk("mult2_start", 32'(mdu.md_start), 1);
        tick(); instr(OP_SPECIAL, 6'h00, 1'b0);
        chk("mult2_armed", 32'(dut.state), 32'(ARMED));
        tick(); mdu.md_busy = 1'b1; interrupt_req = 1'b1;
        chk("mult2_busy", 32'(dut.state), 32'(BUSY));
        tick();
        chk("irq_busy_hold", 32'(dut.state), 32'(BUSY));
        mdu.md_busy = 1'b0;
        tick();
        chk("irq_drain", 32'(dut.state), 32'(DRAIN));
        tick();
        chk("irq_back_idle", 32'(dut.state), 32'(IDLE));
        interrupt_req = 1'b0;

        // reset in BUSY, then mthi issues
        instr(OP_SPECIAL, F_MULTU, 1'b1);
        chk("multu_sign", 32'(mdu.md_sign), 0);
        tick(); instr(OP_SPECIAL, 6'h00, 1'b0);
        tick(); mdu.md_busy = 1'b1; md_use_d = 1'b1;
        chk("pre_rst_busy", 32'(dut.state), 32'(BUSY));
        reset = 1'b1; #1;
        chk("rst_mid_stall", 32'(stall_d), 0);
        tick(); reset = 1'b0; #1;
        chk("rst_mid_idle", 32'(dut.state), 32'(IDLE));
        chk("rst_mid_stall_after", 32'(stall_d), 0);
        instr(OP_SPECIAL, F_MTHI, 1'b1);
        chk("mthi_hlw", 32'(mdu.md_hlwrite), 1);
        chk("mthi_md", 32'(mdu.md_md), 0);
        chk("mthi_nostart", 32'(mdu.md_start), 0);
        tick(); instr(OP_SPECIAL, 6'h00, 1'b0);
        chk("mthi_stays_idle", 32'(dut.state), 32'(IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
